// File: rtl/log_fxp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : log_fxp_pipe
//  Purpose  : Fully pipelined natural logarithm of an unsigned fixed-point
//             input. x is normalised to ln(x) = k*ln2 + ln(1+u) with u in
//             [-0.25, 0.5). ln(1+u) is then evaluated as an N_TERMS Taylor
//             series, one term per stage. A zero input sets out_err.
//  Ports    : CLK, RST     - clock (rising edge), synchronous active-high reset
//             in_data      - x, unsigned, FRAC fractional bits
//             in_valid     - in_data valid
//             in_ready     - unit accepts in_data this cycle
//             out_data     - ln(x), signed, FRAC fractional bits
//             out_valid    - out_data/out_err valid
//             out_ready    - downstream accepts the result this cycle
//             out_err      - input was zero (out_data = most negative value)
//  Revision : 1.0 - initial release
// ============================================================================
module log_fxp_pipe #(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 10,
  parameter int N_TERMS = 4,
  parameter int LN2_FXP = 710
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err
);

  localparam int IW = WIDTH + 2;          // internal u / P / A width
  localparam int PW = 2 * IW;             // full product width
  localparam int KW = $clog2(WIDTH) + 2;  // signed exponent width

  localparam logic signed [IW-1:0] ONE     = IW'(2 ** FRAC);
  localparam logic signed [PW-1:0] LN2_S   = PW'(LN2_FXP);
  localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (WIDTH - 1)) - 1;
  localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (WIDTH - 1));

  // C_n = round(2^FRAC / n), elaboration-time constant.
  function automatic logic signed [IW-1:0] coef(input int n);
    int c;
    c = ((2 ** FRAC) + n / 2) / n;
    return IW'(c);
  endfunction

  // Global advance: the whole pipe moves together or holds together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- normalise
  int                     msb_pos;
  logic [FRAC:0]          m_d;
  logic signed [IW-1:0]   u_d;
  logic signed [KW-1:0]   k_d;
  logic                   zero_d;

  always_comb begin
    msb_pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) msb_pos = i;
    end
  end

  always_comb begin
    zero_d = (in_data == '0);
    if (msb_pos >= FRAC) m_d = (FRAC + 1)'(in_data >> (msb_pos - FRAC));
    else                 m_d = (FRAC + 1)'(in_data << (FRAC - msb_pos));
    // Mantissas >= 1.5 are halved so u stays in [-0.25, 0.5), which keeps
    // the series converging quickly.
    if (m_d[FRAC-1]) begin
      u_d = IW'(m_d[FRAC:1]) - ONE;
      k_d = KW'(msb_pos - FRAC + 1);
    end else begin
      u_d = IW'(m_d) - ONE;
      k_d = KW'(msb_pos - FRAC);
    end
    if (zero_d) begin
      u_d = '0;
      k_d = '0;
    end
  end

  // ------------------------------------------------------------ stage storage
  // Index 0 is the normalise stage, index n the n-th series stage.
  logic                 vld_q  [0:N_TERMS];
  logic signed [KW-1:0] k_q    [0:N_TERMS];
  logic                 zero_q [0:N_TERMS];
  logic signed [IW-1:0] u_q    [0:N_TERMS-1];
  logic signed [IW-1:0] p_q    [0:N_TERMS-1];
  logic signed [IW-1:0] a_q    [1:N_TERMS];

  logic signed [IW-1:0] p_d [1:N_TERMS];
  logic signed [IW-1:0] t_d [1:N_TERMS];
  logic signed [IW-1:0] a_d [1:N_TERMS];

  // The power chain starts at P_0 = 1.0, so P_1 = (1.0*u)>>>FRAC = u exactly
  // and every stage uses the same multiply.
  for (genvar n = 1; n <= N_TERMS; n++) begin : g_series
    localparam logic signed [IW-1:0] C_N = coef(n);
    assign p_d[n] = IW'((PW'(p_q[n-1]) * PW'(u_q[n-1])) >>> FRAC);
    assign t_d[n] = IW'((PW'(p_d[n]) * PW'(C_N)) >>> FRAC);
    if (n == 1) begin : g_first
      assign a_d[n] = t_d[n];
    end else if (n % 2 == 1) begin : g_add
      assign a_d[n] = a_q[n-1] + t_d[n];
    end else begin : g_sub
      assign a_d[n] = a_q[n-1] - t_d[n];
    end
  end

  // ------------------------------------------------------------- final stage
  logic signed [PW-1:0] sum_d;
  logic [WIDTH-1:0]     out_data_d;

  assign sum_d = PW'(a_q[N_TERMS]) + PW'(k_q[N_TERMS]) * LN2_S;

  always_comb begin
    if (zero_q[N_TERMS])     out_data_d = {1'b1, {(WIDTH-1){1'b0}}};
    else if (sum_d > SAT_MAX) out_data_d = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sum_d < SAT_MIN) out_data_d = {1'b1, {(WIDTH-1){1'b0}}};
    else                      out_data_d = sum_d[WIDTH-1:0];
  end

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_err_q;

  // Data registers carry no reset; only the valid bits and outputs do.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n <= N_TERMS; n++) vld_q[n] <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      u_q[0]    <= u_d;
      k_q[0]    <= k_d;
      zero_q[0] <= zero_d;
      p_q[0]    <= ONE;
      for (int n = 1; n <= N_TERMS; n++) begin
        vld_q[n]  <= vld_q[n-1];
        k_q[n]    <= k_q[n-1];
        zero_q[n] <= zero_q[n-1];
        a_q[n]    <= a_d[n];
      end
      for (int n = 1; n < N_TERMS; n++) begin
        u_q[n] <= u_q[n-1];
        p_q[n] <= p_d[n];
      end
      out_valid_q <= vld_q[N_TERMS];
      out_data_q  <= out_data_d;
      out_err_q   <= zero_q[N_TERMS];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_log_fxp_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_log_fxp_pipe
//  Purpose  : Directed self-checking bench for log_fxp_pipe (default build
//             plus a 2-term / FRAC=12 build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_log_fxp_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_err;

  logic [31:0] in_data2 = '0;
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] out_data2;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic        out_err2;

  always #5 CLK = ~CLK;

  log_fxp_pipe dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_err(out_err)
  );

  log_fxp_pipe #(.WIDTH(32), .FRAC(12), .N_TERMS(2), .LN2_FXP(2839)) dut2 (
    .CLK(CLK), .RST(RST),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_err(out_err2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 0;
  bit chk_lat = 0;
  bit rdy_rand = 0;

  logic [31:0] q_d[$];
  logic        q_e[$];
  int          q_t[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the handshake edge.
  task automatic send(input logic [31:0] x, input int ed, input logic ee);
    int w;
    q_d.push_back(32'(ed));
    q_e.push_back(ee);
    in_data  = x;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge CLK);
      if (in_ready || w >= 1000) break;
      w++;
    end
    check("send_timeout", 64'(w >= 1000), 64'(0));
    @(posedge CLK); #2;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input int max_cyc);
    int w;
    w = 0;
    while (q_d.size() > 0 && w < max_cyc) begin
      @(negedge CLK);
      w++;
    end
    check("drain_left", q_d.size(), 0);
    @(posedge CLK); #2;
  endtask

  // Output scoreboard, handshake rule and stall-stability monitor.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_e;
    logic [31:0] ed;
    logic        ee;
    int          t;
    prev_stall = 0;
    prev_d = '0;
    prev_e = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en && !RST) begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_d);
          check("hold_err", out_err, prev_e);
        end
        if (in_valid && in_ready) q_t.push_back(cyc);
        if (out_valid && out_ready) begin
          if (q_d.size() == 0) begin
            check("spurious_out", out_valid, 0);
          end else begin
            ed = q_d.pop_front();
            ee = q_e.pop_front();
            t  = (q_t.size() > 0) ? q_t.pop_front() : 0;
            check("out_data", out_data, ed);
            check("out_err", out_err, ee);
            if (chk_lat) check("latency", cyc - t, 6);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_e = out_err;
      end else begin
        prev_stall = 0;
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    mon_en  = 1;
    chk_lat = 1;
    @(posedge CLK); #2;

    // Directed values, back to back.
    send(32'd1024, 0, 1'b0);
    send(32'd2048, 710, 1'b0);
    send(32'd512, -710, 1'b0);
    send(32'd1280, 228, 1'b0);
    send(32'd1536, 415, 1'b0);
    send(32'd0, int'(32'h8000_0000), 1'b1);
    send(32'd1, -7100, 1'b0);                // k=-10, u=0
    send(32'd3, -5975, 1'b0);                // m=1.5 -> u=-0.25, k=-8
    send(32'hFFFF_FFFF, 15619, 1'b0);        // u=-1 LSB, k=22
    idle();
    drain(100);

    // Two-term build: ln(1.25) ~ u - u^2/2 = 1024 - 128 at FRAC=12.
    in_data2  = 32'd5120;
    in_valid2 = 1'b1;
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      #1;
      in_valid2 = 1'b0;
    end while (!out_valid2 && lat < 20);
    check("t2_latency", lat, 4);
    check("t2_data", out_data2, 896);
    check("t2_err", out_err2, 0);
    @(posedge CLK); #2;

    // Stream with random back-pressure.
    chk_lat  = 0;
    rdy_rand = 1;
    send(32'd1024, 0, 1'b0);
    send(32'd2048, 710, 1'b0);
    send(32'd512, -710, 1'b0);
    send(32'd1280, 228, 1'b0);
    send(32'd1536, 415, 1'b0);
    send(32'd2560, 938, 1'b0);
    send(32'd3072, 1125, 1'b0);
    send(32'd4096, 1420, 1'b0);
    send(32'd256, -1420, 1'b0);
    send(32'd640, -482, 1'b0);
    idle();
    drain(500);
    rdy_rand = 0;
    @(posedge CLK); #2;

    // Reset with three samples in flight.
    chk_lat = 1;
    send(32'd1024, 0, 1'b0);
    send(32'd1280, 228, 1'b0);
    send(32'd1536, 415, 1'b0);
    idle();
    RST = 1'b1;
    q_d.delete();
    q_e.delete();
    q_t.delete();
    @(posedge CLK); #2;
    RST = 1'b0;
    @(negedge CLK);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (10) @(negedge CLK);
    @(posedge CLK); #2;
    send(32'd2048, 710, 1'b0);
    idle();
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
